// File: rtl/lz_pkg.sv
// Shared types, sizes and helpers for the leading-zero stream transmitter.
package lz_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned WORD      = 16;
  localparam int unsigned MAX_ZEROS = 256;
  localparam int unsigned ZW        = 9;   // request/count width
  localparam int unsigned RW        = 3;   // bit position within a byte
  localparam int unsigned FW        = ZW - RW; // whole zero bytes, up to MAX_ZEROS/WIDTH
  localparam int unsigned CW        = 5;   // byte counter, holds 0..WORD

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Word plan derived from a clamped request.
  typedef struct packed {
    logic [FW-1:0] f;       // full zero bytes
    logic [RW-1:0] r;       // zeros ahead of the leading one in byte f
    logic [CW-1:0] nbytes;  // bytes to stream for this word
  } plan_t;

  function automatic logic [ZW-1:0] clamp_zeros(input logic [ZW-1:0] z);
    return (z > ZW'(MAX_ZEROS)) ? ZW'(MAX_ZEROS) : z;
  endfunction

  function automatic plan_t make_plan(input logic [ZW-1:0] z, input logic mode);
    plan_t p;
    p.f = z[ZW-1:RW];
    p.r = z[RW-1:0];
    // Early-terminate stops after the byte holding the leading one.
    if (mode && (p.f < FW'(WORD)))
      p.nbytes = CW'(p.f + FW'(1));
    else
      p.nbytes = CW'(WORD);
    return p;
  endfunction

endpackage

// File: rtl/lz_stream_tx_if.sv
// Request and byte-stream bundle between a request source and lz_stream_tx.
interface lz_stream_tx_if;
  import lz_pkg::*;

  logic             REQ_VALID;
  logic             REQ_READY;
  logic [ZW-1:0]    REQ_ZEROS;
  logic             REQ_MODE;
  logic [WIDTH-1:0] DATA;
  logic             IVALID;
  logic             MODE;
  logic [ZW-1:0]    EXP_ZEROS;
  logic             DONE;

  modport master (
    output REQ_VALID, REQ_ZEROS, REQ_MODE,
    input  REQ_READY, DATA, IVALID, MODE, EXP_ZEROS, DONE
  );

  modport slave (
    input  REQ_VALID, REQ_ZEROS, REQ_MODE,
    output REQ_READY, DATA, IVALID, MODE, EXP_ZEROS, DONE
  );
endinterface

// File: rtl/lz_lfsr8.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) used for random fill bytes.
// Only present when LZ_STREAM_LFSR_FILL_EN is defined.
`ifdef LZ_STREAM_LFSR_FILL_EN
module lz_lfsr8 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i)
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule
`endif

// File: rtl/lz_stream_tx.sv
// Streams a WORD-byte MSB-first word whose leading-zero count equals the request.
// LZ_STREAM_LFSR_FILL_EN: fill bits come from an LFSR instead of all ones.
module lz_stream_tx
  import lz_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2  // idle-stream cycles between words, >= 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  lz_stream_tx_if.slave bus
);

  localparam int unsigned GW = 4;

  state_e           state_q, state_d;
  plan_t            plan_q, plan_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ivalid_q, ivalid_d;
  logic             mode_q, mode_d;
  logic [ZW-1:0]    exp_q, exp_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [ZW-1:0]    z_clamped;
  plan_t            new_plan;
  plan_t            sel_plan;
  logic [CW-1:0]    sel_k;
  logic [WIDTH-1:0] lead;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] below_en;
  logic [WIDTH-1:0] byte_nxt;

`ifdef LZ_STREAM_LFSR_FILL_EN
  logic [7:0] lfsr;
  lz_lfsr8 u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en_i  (ivalid_d),
    .q_o   (lfsr)
  );
  assign fill     = lfsr;
  assign below_en = '1;
`else
  assign fill     = '1;
  assign below_en = '0;
`endif

  assign z_clamped = clamp_zeros(bus.REQ_ZEROS);
  assign new_plan  = make_plan(z_clamped, bus.REQ_MODE);

  // Next byte to present: byte 0 of a fresh request while idle, else byte cnt_q.
  always_comb begin
    sel_plan = (state_q == IDLE) ? new_plan : plan_q;
    sel_k    = (state_q == IDLE) ? '0 : cnt_q;
    lead     = WIDTH'(8'h80) >> sel_plan.r;
    if (FW'(sel_k) < sel_plan.f)
      byte_nxt = '0;
    else if (FW'(sel_k) == sel_plan.f)
      byte_nxt = lead | (fill & (lead - WIDTH'(1)) & below_en);
    else
      byte_nxt = fill;
  end

  always_comb begin
    state_d  = state_q;
    plan_d   = plan_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    data_d   = data_q;
    ivalid_d = 1'b0;
    mode_d   = mode_q;
    exp_d    = exp_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.REQ_VALID && ready_q) begin
          state_d  = SEND;
          plan_d   = new_plan;
          mode_d   = bus.REQ_MODE;
          exp_d    = z_clamped;
          data_d   = byte_nxt;
          ivalid_d = 1'b1;
          cnt_d    = CW'(1);
        end
      end
      SEND: begin
        if (cnt_q == plan_q.nbytes) begin
          state_d = GAP;
          gap_d   = '0;
          done_d  = 1'b1;
        end else begin
          data_d   = byte_nxt;
          ivalid_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      GAP: begin
        // The IDLE cycle that follows also has IVALID low, so it counts toward the gap.
        if (gap_q >= GW'(GAP_CYCLES - 2))
          state_d = IDLE;
        else
          gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      plan_q   <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      ivalid_q <= 1'b0;
      mode_q   <= 1'b0;
      exp_q    <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      plan_q   <= plan_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      ivalid_q <= ivalid_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.DATA      = data_q;
  assign bus.IVALID    = ivalid_q;
  assign bus.MODE      = mode_q;
  assign bus.EXP_ZEROS = exp_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_lz_stream_tx.sv
// Scoreboard bench for lz_stream_tx (default build, fill bytes 8'hFF).
module tb_lz_stream_tx;
  import lz_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  lz_stream_tx_if bus();

  lz_stream_tx #(.GAP_CYCLES(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   nbytes;
    int   zeros;
    logic mode;
  } word_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_bytes[$];
  word_t      exp_words[$];

  // Monitor state
  int   got_bytes = 0;
  int   lz_acc    = 0;
  bit   seen_one  = 0;
  bit   last_prev = 0;
  int   low_run   = 0;
  bit   gap_check_en = 0;
  bit   gap_armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Expected byte k of a word with z leading zeros, one marker bit then FF fill bytes.
  function automatic logic [7:0] model_byte(input int k, input int z);
    logic [7:0] top;
    top = 8'h80;
    if (8*k + 8 <= z) return 8'h00;
    else if (8*k <= z) return top >> (z - 8*k);
    else return 8'hFF;
  endfunction

  function automatic int lz_of_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      if (b[i]) return 7 - i;
    return 8;
  endfunction

  task automatic queue_word(input int zr, input logic mode);
    word_t w;
    int z;
    int n;
    z = (zr > 256) ? 256 : zr;
    n = 16;
    if (mode) n = ((z / 8 + 1) < 16) ? (z / 8 + 1) : 16;
    for (int k = 0; k < n; k++) exp_bytes.push_back(model_byte(k, z));
    w.nbytes = n;
    w.zeros  = z;
    w.mode   = mode;
    exp_words.push_back(w);
  endtask

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge CLK) begin
    if (!RST_N) begin
      got_bytes = 0;
      lz_acc    = 0;
      seen_one  = 0;
      last_prev = 0;
      low_run   = 0;
      gap_armed = 0;
    end else begin
      if (last_prev) check("done_after_last", bus.DONE, 1);
      last_prev = 0;
      if (bus.IVALID) begin
        if (exp_bytes.size() == 0) begin
          check("unexpected_byte", bus.DATA, 32'hFFFF_FFFF);
        end else begin
          check("byte", bus.DATA, exp_bytes.pop_front());
        end
        if (exp_words.size() > 0) begin
          check("exp_zeros", bus.EXP_ZEROS, exp_words[0].zeros);
          check("mode", bus.MODE, exp_words[0].mode);
        end
        check("ready_busy", bus.REQ_READY, 0);
        if (gap_armed && gap_check_en && got_bytes == 0) begin
          check("gap_len", low_run, 2);
          gap_armed = 0;
        end
        got_bytes++;
        if (!seen_one) begin
          if (bus.DATA == 8'h00) lz_acc += 8;
          else begin
            lz_acc  += lz_of_byte(bus.DATA);
            seen_one = 1;
          end
        end
        low_run = 0;
        if (exp_words.size() > 0 && got_bytes == exp_words[0].nbytes) last_prev = 1;
      end else begin
        low_run++;
      end
      if (bus.DONE) begin
        word_t w;
        check("done_ivalid_low", bus.IVALID, 0);
        check("done_ready_low", bus.REQ_READY, 0);
        if (exp_words.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          w = exp_words.pop_front();
          check("byte_count", got_bytes, w.nbytes);
          check("lz_count", lz_acc, (w.zeros > 128) ? 128 : w.zeros);
        end
        got_bytes = 0;
        lz_acc    = 0;
        seen_one  = 0;
        gap_armed = gap_check_en;
      end
    end
  end

  task automatic wait_ready();
    int i;
    i = 0;
    @(negedge CLK);
    while (!bus.REQ_READY && i < 300) begin
      @(negedge CLK);
      i++;
    end
    if (!bus.REQ_READY) check("ready_timeout", bus.REQ_READY, 1);
  endtask

  task automatic do_req(input int z, input logic mode);
    wait_ready();
    bus.REQ_VALID = 1'b1;
    bus.REQ_ZEROS = 9'(z > 511 ? 511 : z);
    bus.REQ_MODE  = mode;
    queue_word(z, mode);
    @(posedge CLK);
    #1 bus.REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_words.size() != 0 || exp_bytes.size() != 0 || !bus.REQ_READY) && i < 500) begin
      @(negedge CLK);
      i++;
    end
    if (exp_words.size() != 0) check("drain_timeout", exp_words.size(), 0);
  endtask

  initial begin
    int acc;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ZEROS = '0;
    bus.REQ_MODE  = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_data", bus.DATA, 0);
    check("rst_ivalid", bus.IVALID, 0);
    check("rst_mode", bus.MODE, 0);
    check("rst_exp_zeros", bus.EXP_ZEROS, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_ready", bus.REQ_READY, 1);

    // Full and early-terminate words, including clamp and byte-boundary cases
    do_req(0, 1'b0);
    drain();
    do_req(19, 1'b0);
    do_req(19, 1'b1);
    do_req(300, 1'b0);
    do_req(300, 1'b1);
    do_req(7, 1'b1);
    do_req(8, 1'b1);
    do_req(127, 1'b1);
    do_req(128, 1'b1);
    do_req(256, 1'b0);
    do_req(129, 1'b0);
    drain();

    // REQ_VALID held across two back-to-back words
    gap_check_en = 1;
    wait_ready();
    bus.REQ_VALID = 1'b1;
    bus.REQ_ZEROS = 9'd19;
    bus.REQ_MODE  = 1'b1;
    queue_word(19, 1'b1);
    queue_word(19, 1'b1);
    acc = 0;
    for (int i = 0; i < 200 && acc < 2; i++) begin
      if (bus.REQ_READY) acc++;
      if (acc < 2) @(negedge CLK);
    end
    check("held_accepts", acc, 2);
    @(posedge CLK);
    #1 bus.REQ_VALID = 1'b0;
    drain();
    gap_check_en = 0;

    // Reset in the middle of a word
    do_req(0, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    check("pre_rst_ivalid", bus.IVALID, 1);
    check("pre_rst_byte5", bus.DATA, 8'hFF);
    RST_N = 1'b0;
    #1;
    check("midrst_ivalid", bus.IVALID, 0);
    check("midrst_done", bus.DONE, 0);
    check("midrst_ready", bus.REQ_READY, 1);
    exp_bytes.delete();
    exp_words.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_ready", bus.REQ_READY, 1);
    check("post_rst_ivalid", bus.IVALID, 0);
    check("post_rst_done", bus.DONE, 0);
    repeat (20) @(posedge CLK);

    // Recovery after reset
    do_req(19, 1'b0);
    drain();
    repeat (3) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
